// File: rtl/latch_bank_ctrl.sv
// latch_bank_ctrl: round-robin write sequencer for a bank of NLAT 8-bit latches with shadow readback
// Ports: req_valid/req_addr/req_data/req_ready form two write requesters; done/err report completion;
// lat_d/lat_en/lat_rst drive the latch bank; rd_addr/rd_data read the registered shadow copy.
// Optional LATCH_BANK_CLEAR_EN adds input clr, which restarts INIT from IDLE and clears all shadows.
module latch_bank_ctrl #(
  parameter int NLAT = 4,
  parameter int EN_CYCLES = 1
) (
  input  logic            clk,
  input  logic            rst,
`ifdef LATCH_BANK_CLEAR_EN
  input  logic            clr,
`endif
  input  logic [1:0]      req_valid,
  input  logic [3:0]      req_addr,
  input  logic [15:0]     req_data,
  output logic [1:0]      req_ready,
  output logic [1:0]      done,
  output logic            err,
  output logic            busy,
  output logic [7:0]      lat_d,
  output logic [NLAT-1:0] lat_en,
  output logic            lat_rst,
  input  logic [1:0]      rd_addr,
  output logic [7:0]      rd_data
);
  typedef enum logic [2:0] {INIT, IDLE, SETUP, PULSE, HOLD} state_t;
  state_t st, st_n;
  logic ptr, own, clr_q, xfer, wi, bad;
  logic [1:0] addr, gnt;
  logic [3:0] cnt;
  logic [7:0] shadow [4];
`ifndef LATCH_BANK_CLEAR_EN
  logic clr;
  assign clr = 1'b0;
`endif
  assign xfer = |(req_valid & req_ready);
  assign wi = req_ready[1];
  assign bad = int'(addr) >= NLAT;
  // ready is computed one edge ahead from the sampled valids, so the grant is a pure register
  assign gnt = ptr ? (req_valid[1] ? 2'b10 : {1'b0, req_valid[0]})
                   : (req_valid[0] ? 2'b01 : {req_valid[1], 1'b0});
  always_comb begin
    st_n = st;
    case (st)
      INIT:    st_n = IDLE;
      IDLE:    st_n = clr_q ? INIT : xfer ? SETUP : IDLE;
      SETUP:   st_n = PULSE;
      PULSE:   st_n = (cnt == 4'(EN_CYCLES - 1)) ? HOLD : PULSE;
      HOLD:    st_n = IDLE;
      default: st_n = INIT;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      st <= INIT;
      ptr <= 1'b0;
      own <= 1'b0;
      addr <= 2'd0;
      cnt <= 4'd0;
      clr_q <= 1'b0;
      lat_d <= 8'd0;
      req_ready <= 2'b00;
      done <= 2'b00;
      err <= 1'b0;
      busy <= 1'b1;
      lat_en <= '0;
      lat_rst <= 1'b1;
      rd_data <= 8'd0;
      shadow <= '{default: 8'h00};
    end else begin
      st <= st_n;
      cnt <= (st == PULSE) ? cnt + 4'd1 : 4'd0;
      if (xfer) begin
        ptr <= ~wi;
        own <= wi;
        addr <= wi ? req_addr[3:2] : req_addr[1:0];
        lat_d <= wi ? req_data[15:8] : req_data[7:0];
      end
      // a clear seen in IDLE is acted on next cycle, with ready already forced low
      clr_q <= clr && (st_n == IDLE);
      req_ready <= (st_n == IDLE && !clr) ? gnt : 2'b00;
      done <= (st_n == HOLD) ? (own ? 2'b10 : 2'b01) : 2'b00;
      err <= (st_n == HOLD) && bad;
      busy <= st_n != IDLE;
      lat_en <= (st_n == PULSE && !bad) ? NLAT'(1) << addr : '0;
      lat_rst <= st_n == INIT;
      rd_data <= shadow[rd_addr];
      if (st == HOLD && !bad) shadow[addr] <= lat_d;
      if (st == IDLE && clr_q) shadow <= '{default: 8'h00};
    end
  end
endmodule

// File: tb/tb_latch_bank_ctrl.sv
// tb_latch_bank_ctrl: scoreboard bench for latch_bank_ctrl with a shadow-array reference model
module tb_latch_bank_ctrl;
  localparam int NLAT = 3, EN = 2;
  logic clk = 1'b0, rst = 1'b1;
  logic [1:0] req_valid = 2'b00, rd_addr = 2'b00;
  logic [3:0] req_addr = 4'd0;
  logic [15:0] req_data = 16'd0;
  logic [1:0] req_ready, done;
  logic err, busy, lat_rst;
  logic [7:0] lat_d, rd_data;
  logic [NLAT-1:0] lat_en;
`ifdef LATCH_BANK_CLEAR_EN
  logic clr = 1'b0;
`endif
  always #5 clk = ~clk;

  latch_bank_ctrl #(.NLAT(NLAT), .EN_CYCLES(EN)) dut (
    .clk(clk), .rst(rst),
`ifdef LATCH_BANK_CLEAR_EN
    .clr(clr),
`endif
    .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data), .req_ready(req_ready),
    .done(done), .err(err), .busy(busy), .lat_d(lat_d), .lat_en(lat_en), .lat_rst(lat_rst),
    .rd_addr(rd_addr), .rd_data(rd_data)
  );

  typedef struct {int req; int addr; int data; int cyc;} exp_t;
  exp_t q[$];
  int gq[$];
  int model[4] = '{0, 0, 0, 0};
  int errors = 0, checks = 0, cyc = 0;
  int en_cnt = 0, en_val = 0, en_first = 0;
  int bus_err = 0, oh_err = 0, rr_err = 0, lone_err = 0, lr_cnt = 0, lr_last = 0, acc_last = 0;
  logic [7:0] prev_d = 8'd0;
  logic [NLAT-1:0] prev_en = '0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // monitor: records accepted writes and checks each completion against the model
  always @(negedge clk) begin
    exp_t e;
    int bd;
    cyc++;
    if (rst) begin
      en_cnt = 0;
      en_val = 0;
    end else begin
      if ((lat_en != 0 || prev_en != 0) && lat_d != prev_d) bus_err++;
      if (!$onehot0(lat_en)) oh_err++;
      if (req_ready == 2'b11) rr_err++;
      if (err && done == 2'b00) lone_err++;
      if (lat_rst) begin
        lr_cnt++;
        lr_last = cyc;
      end
      if (lat_en != 0) begin
        if (en_cnt == 0) en_first = cyc;
        en_cnt++;
        en_val |= int'(lat_en);
      end
      for (int i = 0; i < 2; i++)
        if (req_valid[i] && req_ready[i]) begin
          q.push_back('{i, int'(req_addr[2*i +: 2]), int'(req_data[8*i +: 8]), cyc});
          gq.push_back(i);
          acc_last = cyc;
        end
      if (done != 2'b00) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL done_unexpected: got done=%b with no write outstanding", done);
        end else begin
          e = q.pop_front();
          bd = (e.addr >= NLAT) ? 1 : 0;
          chk("done_req", int'(done), 1 << e.req);
          chk("err", int'(err), bd);
          chk("latency", cyc - e.cyc, EN + 2);
          chk("en_cycles", en_cnt, bd ? 0 : EN);
          chk("en_select", en_val, bd ? 0 : (1 << e.addr));
          if (bd == 0) chk("setup_gap", en_first - e.cyc, 2);
          chk("lat_d", int'(lat_d), e.data);
          if (bd == 0) model[e.addr] = e.data;
        end
        en_cnt = 0;
        en_val = 0;
      end
    end
    prev_en = lat_en;
    prev_d = lat_d;
  end

  task automatic wr(input int i, input int a, input int d);
    int t = 0;
    req_addr[2*i +: 2] = 2'(a);
    req_data[8*i +: 8] = 8'(d);
    req_valid[i] = 1'b1;
    do begin
      @(negedge clk);
      t++;
    end while (!req_ready[i] && t < 300);
    if (!req_ready[i]) begin
      checks++;
      errors++;
      $display("FAIL wr_timeout: requester %0d got no ready in %0d cycles", i, t);
    end
    @(posedge clk);
    #1 req_valid[i] = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    do begin
      @(negedge clk);
      t++;
    end while ((q.size() != 0 || busy || req_valid != 2'b00) && t < 500);
    chk("idle_reached", int'(t < 500), 1);
  endtask

  task automatic rd_chk(input int a);
    @(posedge clk);
    #1 rd_addr = 2'(a);
    @(posedge clk);
    @(negedge clk);
    chk($sformatf("rd%0d", a), int'(rd_data), model[a]);
  endtask

  initial begin
    int t, dn;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", int'(busy), 1);
    chk("rst_lat_rst", int'(lat_rst), 1);
    chk("rst_outs", int'({req_ready, done, err, lat_en, lat_d, rd_data}), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("init_lat_rst", int'(lat_rst), 1);
    chk("init_busy", int'(busy), 1);
    @(negedge clk);
    chk("idle_lat_rst", int'(lat_rst), 0);
    chk("idle_busy", int'(busy), 0);
    chk("idle_ready", int'(req_ready), 0);

    gq.delete();
    @(posedge clk);
    #1;
    fork
      begin wr(0, 0, 'h11); wr(0, 0, 'h11); end
      begin wr(1, 1, 'h22); wr(1, 1, 'h22); end
    join
    wait_idle();
    for (int k = 0; k < 4; k++) chk($sformatf("grant%0d", k), gq.size() > k ? gq[k] : -1, k % 2);

    wr(0, 2, 'hA5);
    wait_idle();
    rd_chk(2);

    wr(0, 3, 'hFF);
    wait_idle();
    for (int a = 0; a < 4; a++) rd_chk(a);

    fork
      for (int k = 0; k < 10; k++) begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1 wr(0, int'($urandom_range(0, 3)), int'($urandom_range(0, 255)));
      end
      for (int k = 0; k < 10; k++) begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1 wr(1, int'($urandom_range(0, 3)), int'($urandom_range(0, 255)));
      end
    join
    wait_idle();
    for (int a = 0; a < 4; a++) rd_chk(a);

    wr(0, 1, 'h77);
    t = 0;
    while (lat_en == 0 && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("pulse_seen", int'(lat_en != 0), 1);
    @(posedge clk);
    #1 rst = 1'b1;
    q.delete();
    for (int k = 0; k < 4; k++) model[k] = 0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_lat_en", int'(lat_en), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    dn = 0;
    repeat (8) begin
      @(negedge clk);
      if (done != 2'b00) dn++;
    end
    chk("rst_no_done", dn, 0);
    rd_chk(1);

`ifdef LATCH_BANK_CLEAR_EN
    wr(1, 1, 'h5A);
    wait_idle();
    rd_chk(1);
    lr_cnt = 0;
    @(posedge clk);
    #1;
    fork
      wr(0, 0, 'h33);
      begin
        clr = 1'b1;
        for (int k = 0; k < 4; k++) model[k] = 0;
        @(posedge clk);
        #1 clr = 1'b0;
      end
    join
    wait_idle();
    chk("clr_lat_rst_cycles", lr_cnt, 1);
    chk("clr_before_accept", int'(acc_last > lr_last), 1);
    rd_chk(1);
    rd_chk(0);
`endif

    chk("bus_stable", bus_err, 0);
    chk("en_onehot0", oh_err, 0);
    chk("ready_exclusive", rr_err, 0);
    chk("err_with_done", lone_err, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
